control_sequencer: RTL and testbench

//  Hardwired control unit for the Mini SRC datapath. It generates every fetch and

---
 rtl/control_sequencer.sv | 236 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini SRC datapath.
// One T-state per clock: fetch is T0-T2, execute steps follow from the opcode.
// Strobes are a Moore decode of the registered state/step and the IR opcode,
// so an asynchronous reset drops every strobe in the same cycle.
module control_sequencer #(
    parameter int OPC_W       = 5,
    parameter int T_MAX       = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter int MULDIV_WAIT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     mem_ready,
    input  logic [31:0]              ir,
    output logic [10:0]              ctrl_out,
    output logic [8:0]               ctrl_in,
    output logic [12:0]              alu_op,
    output logic [2:0]               gr_sel,
    output logic [2:0]               mem_ctl,
    output logic [$clog2(T_MAX)-1:0] step,
    output logic                     halted,
    output logic                     illegal_op,
    output logic                     bus_err
);
    localparam int SW = $clog2(T_MAX);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam int WW = $clog2(MULDIV_WAIT + 2);

    // bit positions inside the strobe buses
    localparam int O_HI = 10, O_LO = 9, O_ZH = 8, O_ZL = 7, O_MDR = 4, O_C = 2, O_R = 1, O_BA = 0;
    localparam int I_HI = 8, I_LO = 7, I_PC = 6, I_IR = 5, I_Z = 4, I_Y = 3, I_MAR = 2, I_MDR = 1, I_R = 0;
    localparam int A_AND = 12, A_OR = 11, A_ADD = 10, A_SUB = 9, A_MUL = 8, A_DIV = 7;
    localparam int A_SHR = 6, A_SHRA = 5, A_SHL = 4, A_ROR = 3, A_ROL = 2, A_NEG = 1, A_NOT = 0;
    localparam int G_A = 2, G_B = 1, G_C = 0;
    localparam int M_RD = 2, M_INC = 1, M_WR = 0;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_HALTED} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_step;
    logic [TW-1:0]   r_to_cnt;
    logic [WW-1:0]   r_wait_cnt;
    logic            r_bus_err;

    logic [OPC_W-1:0] w_opc;
    logic [31:0]      w_opn;
    logic             w_is_ld, w_is_ldi, w_is_st, w_is_rt, w_is_imm, w_is_md, w_is_nn;
    logic             w_is_nop, w_is_halt, w_is_ill, w_is_mem;
    logic [12:0]      w_alu_sel;
    logic [SW-1:0]    w_last;
    logic             w_stall;
    logic             w_unused_ir;

    assign w_opc       = ir[31 -: OPC_W];
    assign w_opn       = 32'(w_opc);
    assign w_unused_ir = &{1'b0, ir[31-OPC_W:0]};

    assign w_is_ld   = (w_opn == 0);
    assign w_is_ldi  = (w_opn == 1);
    assign w_is_st   = (w_opn == 2);
    assign w_is_rt   = (w_opn >= 3) && (w_opn <= 11);
    assign w_is_imm  = (w_opn >= 12) && (w_opn <= 14);
    assign w_is_md   = (w_opn == 15) || (w_opn == 16);
    assign w_is_nn   = (w_opn == 17) || (w_opn == 18);
    assign w_is_nop  = (w_opn == 26);
    assign w_is_halt = (w_opn == 27);
    assign w_is_ill  = !((w_opn <= 18) || w_is_nop || w_is_halt);
    assign w_is_mem  = w_is_ld || w_is_ldi || w_is_st;

    // opcode -> ALU function: 3 add, 4 sub, 5 shr, 6 shra, 7 shl, 8 ror, 9 rol,
    // 10 and, 11 or, 12 addi, 13 andi, 14 ori, 15 div, 16 mul, 17 neg, 18 not
    always_comb begin
        w_alu_sel = '0;
        case (w_opn)
            3, 12:   w_alu_sel[A_ADD]  = 1'b1;
            4:       w_alu_sel[A_SUB]  = 1'b1;
            5:       w_alu_sel[A_SHR]  = 1'b1;
            6:       w_alu_sel[A_SHRA] = 1'b1;
            7:       w_alu_sel[A_SHL]  = 1'b1;
            8:       w_alu_sel[A_ROR]  = 1'b1;
            9:       w_alu_sel[A_ROL]  = 1'b1;
            10, 13:  w_alu_sel[A_AND]  = 1'b1;
            11, 14:  w_alu_sel[A_OR]   = 1'b1;
            15:      w_alu_sel[A_DIV]  = 1'b1;
            16:      w_alu_sel[A_MUL]  = 1'b1;
            17:      w_alu_sel[A_NEG]  = 1'b1;
            18:      w_alu_sel[A_NOT]  = 1'b1;
            default: ;
        endcase
    end

    // final T-state of the instruction class; illegal opcodes spend T3 pulsing illegal_op
    always_comb begin
        w_last = SW'(3);
        if (w_is_ld || w_is_st)                   w_last = SW'(7);
        else if (w_is_ldi || w_is_rt || w_is_imm) w_last = SW'(5);
        else if (w_is_md)                         w_last = SW'(6);
        else if (w_is_nn)                         w_last = SW'(4);
        else if (w_is_nop || w_is_halt)           w_last = SW'(2);
    end

    // memory steps: fetch read, ld operand read, st write
    assign w_stall = (r_state == S_EXEC) &&
                     ((r_step == SW'(1)) || (w_is_ld && r_step == SW'(6)) ||
                      (w_is_st && r_step == SW'(7)));

    // sequencer state, step counter, memory timeout and mul/div hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_step     <= '0;
            r_to_cnt   <= '0;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (run) begin
                    r_state <= S_EXEC;
                    r_step  <= '0;
                end
                S_EXEC: begin
                    if (w_stall && !mem_ready) begin
                        if (r_to_cnt == TW'(MEM_TIMEOUT - 1)) begin
                            r_state   <= S_HALTED;
                            r_step    <= '0;
                            r_to_cnt  <= '0;
                            r_bus_err <= 1'b1;
                        end else begin
                            r_to_cnt <= r_to_cnt + TW'(1);
                        end
                    end else begin
                        r_to_cnt <= '0;
                        if (r_step == SW'(2) && w_is_halt) begin
                            r_state <= S_HALTED;
                            r_step  <= '0;
                        end else if (r_step == w_last) begin
                            // run is only looked at when a new instruction would start
                            r_state <= run ? S_EXEC : S_IDLE;
                            r_step  <= '0;
                        end else if (w_is_md && r_step == SW'(4) && MULDIV_WAIT != 0) begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= WW'(1);
                        end else begin
                            r_step <= r_step + SW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == WW'(MULDIV_WAIT)) begin
                        r_state <= S_EXEC;
                        r_step  <= r_step + SW'(1);
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                    end
                end
                S_HALTED: ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Moore strobe decode; WAIT repeats the T4 mul/div strobes. ALU op only rides with Zin.
    always_comb begin
        ctrl_out   = '0;
        ctrl_in    = '0;
        alu_op     = '0;
        gr_sel     = '0;
        mem_ctl    = '0;
        illegal_op = 1'b0;
        if (r_state == S_EXEC || r_state == S_WAIT) begin
            case (r_step)
                SW'(0): begin ctrl_in[I_PC] = 1'b1; ctrl_in[I_MAR] = 1'b1; mem_ctl[M_INC] = 1'b1; end
                SW'(1): begin mem_ctl[M_RD] = 1'b1; ctrl_in[I_MDR] = 1'b1; end
                SW'(2): begin ctrl_out[O_MDR] = 1'b1; ctrl_in[I_IR] = 1'b1; end
                SW'(3): begin
                    if (w_is_mem) begin
                        gr_sel[G_B] = 1'b1; ctrl_out[O_BA] = 1'b1; ctrl_in[I_Y] = 1'b1;
                    end else if (w_is_rt || w_is_imm) begin
                        gr_sel[G_B] = 1'b1; ctrl_out[O_R] = 1'b1; ctrl_in[I_Y] = 1'b1;
                    end else if (w_is_md) begin
                        gr_sel[G_A] = 1'b1; ctrl_out[O_R] = 1'b1; ctrl_in[I_Y] = 1'b1;
                    end else if (w_is_nn) begin
                        gr_sel[G_B] = 1'b1; ctrl_out[O_R] = 1'b1; ctrl_in[I_Z] = 1'b1; alu_op = w_alu_sel;
                    end else if (w_is_ill) begin
                        illegal_op = 1'b1;
                    end
                end
                SW'(4): begin
                    if (w_is_mem) begin
                        ctrl_out[O_C] = 1'b1; ctrl_in[I_Z] = 1'b1; alu_op[A_ADD] = 1'b1;
                    end else if (w_is_rt) begin
                        gr_sel[G_C] = 1'b1; ctrl_out[O_R] = 1'b1; ctrl_in[I_Z] = 1'b1; alu_op = w_alu_sel;
                    end else if (w_is_imm) begin
                        ctrl_out[O_C] = 1'b1; ctrl_in[I_Z] = 1'b1; alu_op = w_alu_sel;
                    end else if (w_is_md) begin
                        gr_sel[G_B] = 1'b1; ctrl_out[O_R] = 1'b1; ctrl_in[I_Z] = 1'b1; alu_op = w_alu_sel;
                    end else if (w_is_nn) begin
                        ctrl_out[O_ZL] = 1'b1; gr_sel[G_A] = 1'b1; ctrl_in[I_R] = 1'b1;
                    end
                end
                SW'(5): begin
                    if (w_is_ldi || w_is_rt || w_is_imm) begin
                        ctrl_out[O_ZL] = 1'b1; gr_sel[G_A] = 1'b1; ctrl_in[I_R] = 1'b1;
                    end else if (w_is_ld || w_is_st) begin
                        ctrl_out[O_ZL] = 1'b1; ctrl_in[I_MAR] = 1'b1;
                    end else if (w_is_md) begin
                        ctrl_out[O_ZL] = 1'b1; ctrl_in[I_LO] = 1'b1;
                    end
                end
                SW'(6): begin
                    if (w_is_ld) begin
                        mem_ctl[M_RD] = 1'b1; ctrl_in[I_MDR] = 1'b1;
                    end else if (w_is_st) begin
                        gr_sel[G_A] = 1'b1; ctrl_out[O_R] = 1'b1; ctrl_in[I_MDR] = 1'b1;
                    end else if (w_is_md) begin
                        ctrl_out[O_ZH] = 1'b1; ctrl_in[I_HI] = 1'b1;
                    end
                end
                SW'(7): begin
                    if (w_is_ld) begin
                        ctrl_out[O_MDR] = 1'b1; gr_sel[G_A] = 1'b1; ctrl_in[I_R] = 1'b1;
                    end else if (w_is_st) begin
                        mem_ctl[M_WR] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign step    = r_step;
    assign halted  = (r_state == S_HALTED);
    assign bus_err = r_bus_err;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a table-driven micro-step model
// expands each instruction into expected per-cycle strobe sets; a monitor
// compares every pushed expectation against the DUT on the falling edge.
module tb_control_sequencer;
    localparam int MEM_TIMEOUT = 15;
    localparam int MULDIV_WAIT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = '0;
    logic [10:0] ctrl_out;
    logic [8:0]  ctrl_in;
    logic [12:0] alu_op;
    logic [2:0]  gr_sel, mem_ctl, step;
    logic        halted, illegal_op, bus_err;

    always #5 clk = ~clk;

    control_sequencer #(
        .OPC_W(5), .T_MAX(8), .MEM_TIMEOUT(MEM_TIMEOUT), .MULDIV_WAIT(MULDIV_WAIT)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
        .ctrl_out(ctrl_out), .ctrl_in(ctrl_in), .alu_op(alu_op), .gr_sel(gr_sel),
        .mem_ctl(mem_ctl), .step(step), .halted(halted), .illegal_op(illegal_op),
        .bus_err(bus_err)
    );

    // strobe masks
    localparam logic [10:0] HIout = 11'h400, Zhighout = 11'h100, Zlowout = 11'h080,
                            MDRout = 11'h010, Cout = 11'h004, Rout = 11'h002, BAout = 11'h001;
    localparam logic [8:0]  HIin = 9'h100, LOin = 9'h080, PCin = 9'h040, IRin = 9'h020, Zin = 9'h010,
                            Yin = 9'h008, MARin = 9'h004, MDRin = 9'h002, Rin = 9'h001;
    localparam logic [12:0] AND_ = 13'h1000, OR_ = 13'h0800, ADD_ = 13'h0400, SUB_ = 13'h0200,
                            MUL_ = 13'h0100, DIV_ = 13'h0080, SHR_ = 13'h0040, SHRA_ = 13'h0020,
                            SHL_ = 13'h0010, ROR_ = 13'h0008, ROL_ = 13'h0004, NEG_ = 13'h0002,
                            NOT_ = 13'h0001;
    localparam logic [2:0]  Gra = 3'b100, Grb = 3'b010, Grc = 3'b001;
    localparam logic [2:0]  Read = 3'b100, IncPC = 3'b010, WrMem = 3'b001;

    typedef struct packed {
        logic [10:0] co;
        logic [8:0]  ci;
        logic [12:0] alu;
        logic [2:0]  gr;
        logic [2:0]  mem;
        logic [2:0]  stp;
        logic        hlt;
        logic        ill;
        logic        berr;
    } exp_t;

    typedef struct {
        exp_t e;
        bit   stall;
    } ustep_t;

    exp_t        sb_q[$];
    ustep_t      useq[$];
    int          checks = 0;
    int          errors = 0;
    bit          model_idle = 1'b1;
    bit          model_berr = 1'b0;
    bit          fin_req = 1'b0;
    event        imm_ev, fin_ev;
    logic [12:0] alu_of[32];

    function automatic void add(input int s, input logic [10:0] co, input logic [8:0] ci,
                                input logic [12:0] al, input logic [2:0] gr, input logic [2:0] mm,
                                input bit stall, input bit ill);
        ustep_t u;
        u.e     = '0;
        u.e.co  = co;
        u.e.ci  = ci;
        u.e.alu = al;
        u.e.gr  = gr;
        u.e.mem = mm;
        u.e.stp = 3'(s);
        u.e.ill = ill;
        u.stall = stall;
        useq.push_back(u);
    endfunction

    // micro-step list for one instruction, straight from the step tables
    function automatic void build(input int op);
        useq.delete();
        add(0, '0, PCin | MARin, '0, '0, IncPC, 1'b0, 1'b0);
        add(1, '0, MDRin, '0, '0, Read, 1'b1, 1'b0);
        add(2, MDRout, IRin, '0, '0, '0, 1'b0, 1'b0);
        if (op <= 2) begin
            add(3, BAout, Yin, '0, Grb, '0, 1'b0, 1'b0);
            add(4, Cout, Zin, ADD_, '0, '0, 1'b0, 1'b0);
            if (op == 1) add(5, Zlowout, Rin, '0, Gra, '0, 1'b0, 1'b0);
            else         add(5, Zlowout, MARin, '0, '0, '0, 1'b0, 1'b0);
            if (op == 0) begin
                add(6, '0, MDRin, '0, '0, Read, 1'b1, 1'b0);
                add(7, MDRout, Rin, '0, Gra, '0, 1'b0, 1'b0);
            end else if (op == 2) begin
                add(6, Rout, MDRin, '0, Gra, '0, 1'b0, 1'b0);
                add(7, '0, '0, '0, '0, WrMem, 1'b1, 1'b0);
            end
        end else if (op <= 14) begin
            add(3, Rout, Yin, '0, Grb, '0, 1'b0, 1'b0);
            if (op <= 11) add(4, Rout, Zin, alu_of[op], Grc, '0, 1'b0, 1'b0);
            else          add(4, Cout, Zin, alu_of[op], '0, '0, 1'b0, 1'b0);
            add(5, Zlowout, Rin, '0, Gra, '0, 1'b0, 1'b0);
        end else if (op <= 16) begin
            add(3, Rout, Yin, '0, Gra, '0, 1'b0, 1'b0);
            for (int k = 0; k <= MULDIV_WAIT; k++) add(4, Rout, Zin, alu_of[op], Grb, '0, 1'b0, 1'b0);
            add(5, Zlowout, LOin, '0, '0, '0, 1'b0, 1'b0);
            add(6, Zhighout, HIin, '0, '0, '0, 1'b0, 1'b0);
        end else if (op <= 18) begin
            add(3, Rout, Zin, alu_of[op], Grb, '0, 1'b0, 1'b0);
            add(4, Zlowout, Rin, '0, Gra, '0, 1'b0, 1'b0);
        end else if (op != 26 && op != 27) begin
            add(3, '0, '0, '0, '0, '0, 1'b0, 1'b1);
        end
    endfunction

    // monitor: one comparison per pushed expectation
    initial begin
        exp_t x, a;
        forever begin
            @(negedge clk or imm_ev or fin_ev);
            if (fin_req) begin
                checks++;
                if (sb_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
                end
                break;
            end
            if (sb_q.size() != 0) begin
                x = sb_q.pop_front();
                a = {ctrl_out, ctrl_in, alu_op, gr_sel, mem_ctl, step, halted, illegal_op, bus_err};
                checks++;
                if (a !== x) begin
                    errors++;
                    $display("FAIL cycle t=%0t: got co=%h ci=%h alu=%h gr=%b mem=%b step=%0d halt=%b ill=%b berr=%b; want co=%h ci=%h alu=%h gr=%b mem=%b step=%0d halt=%b ill=%b berr=%b",
                             $time, a.co, a.ci, a.alu, a.gr, a.mem, a.stp, a.hlt, a.ill, a.berr,
                             x.co, x.ci, x.alu, x.gr, x.mem, x.stp, x.hlt, x.ill, x.berr);
                end
            end
        end
    end

    // one clock cycle: drive inputs, log the expected outputs for it
    task automatic cyc(input bit r, input bit mr, input exp_t x);
        run       = r;
        mem_ready = mr;
        x.berr    = model_berr;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        exp_t z;
        z = '0;
        repeat (n) cyc(1'b0, 1'($urandom), z);
    endtask

    task automatic halted_cycles(input int n);
        exp_t h;
        h = '0;
        h.hlt = 1'b1;
        repeat (n) cyc(1'b1, 1'($urandom), h);
    endtask

    // fdelay: >=0 fixed mem_ready delay, -1 random, -2 never ready (timeout)
    // status: 0 completed, 1 halted, 2 stopped inside ld T6 stall
    task automatic run_instr(input logic [31:0] instr, input bit run_after, input int fdelay,
                             input bit abort6, output int status);
        exp_t   z;
        ustep_t u;
        bit     last;
        int     d;
        int     op;
        z      = '0;
        status = 0;
        op     = int'(instr[31:27]);
        ir     = instr;
        if (model_idle) begin
            cyc(1'b1, 1'($urandom), z);
            model_idle = 1'b0;
        end
        build(op);
        for (int i = 0; i < useq.size(); i++) begin
            u    = useq[i];
            last = (i == useq.size() - 1);
            if (u.stall) begin
                if (fdelay == -2) begin
                    repeat (MEM_TIMEOUT) cyc(1'($urandom), 1'b0, u.e);
                    model_berr = 1'b1;
                    status     = 1;
                    return;
                end
                if (abort6 && u.e.stp == 3'd6) begin
                    cyc(1'($urandom), 1'b0, u.e);
                    status = 2;
                    return;
                end
                d = (fdelay >= 0) ? fdelay : int'($urandom_range(0, 3));
                for (int c = 0; c <= d; c++) cyc(last ? run_after : 1'($urandom), (c == d), u.e);
            end else begin
                cyc(last ? run_after : 1'($urandom), 1'($urandom), u.e);
            end
        end
        if (op == 27) status = 1;
        else          model_idle = !run_after;
    endtask

    // async reset from the middle of a cycle; outputs must clear at once
    task automatic do_reset();
        exp_t z;
        z          = '0;
        reset      = 1'b0;
        run        = 1'b0;
        mem_ready  = 1'b0;
        model_berr = 1'b0;
        #1;
        sb_q.push_back(z);
        ->imm_ev;
        #1;
        sb_q.push_back(z);
        @(posedge clk);
        #1;
        reset      = 1'b1;
        model_idle = 1'b1;
    endtask

    initial begin
        int         st;
        logic [4:0] op;
        exp_t       z;
        z = '0;
        foreach (alu_of[i]) alu_of[i] = '0;
        alu_of[3]  = ADD_;  alu_of[4]  = SUB_;  alu_of[5]  = SHR_;  alu_of[6]  = SHRA_;
        alu_of[7]  = SHL_;  alu_of[8]  = ROR_;  alu_of[9]  = ROL_;  alu_of[10] = AND_;
        alu_of[11] = OR_;   alu_of[12] = ADD_;  alu_of[13] = AND_;  alu_of[14] = OR_;
        alu_of[15] = DIV_;  alu_of[16] = MUL_;  alu_of[17] = NEG_;  alu_of[18] = NOT_;

        // reset state
        #1 reset = 1'b0;
        #1;
        sb_q.push_back(z);
        ->imm_ev;
        @(posedge clk);
        #1 reset = 1'b1;
        idle_cycles(2);

        // directed cases
        run_instr(32'h09080045, 1'b1, 0, 1'b0, st);
        run_instr({5'd0, 27'($urandom)}, 1'b1, 3, 1'b0, st);
        run_instr({5'd16, 27'($urandom)}, 1'b1, -1, 1'b0, st);
        run_instr({5'd31, 27'($urandom)}, 1'b1, -1, 1'b0, st);
        run_instr({5'd2, 27'($urandom)}, 1'b0, -1, 1'b0, st);
        idle_cycles(2);

        // random program
        for (int n = 0; n < 60; n++) begin
            op = 5'($urandom);
            if (op == 5'd27) op = 5'd26;
            if (model_idle) idle_cycles(int'($urandom_range(0, 2)));
            run_instr({op, 27'($urandom)}, ($urandom % 4) != 0, -1, 1'b0, st);
        end

        // halt stays halted with run high, only reset leaves
        run_instr({5'd27, 27'($urandom)}, 1'b1, -1, 1'b0, st);
        halted_cycles(4);
        do_reset();
        idle_cycles(2);

        // memory timeout on the fetch read
        run_instr({5'd3, 27'($urandom)}, 1'b1, -2, 1'b0, st);
        halted_cycles(3);
        do_reset();
        idle_cycles(1);

        // reset in the middle of a ld operand read, then recover
        run_instr({5'd0, 27'($urandom)}, 1'b1, -1, 1'b1, st);
        do_reset();
        idle_cycles(3);
        run_instr(32'h09080045, 1'b0, -1, 1'b0, st);
        idle_cycles(2);

        fin_req = 1'b1;
        ->fin_ev;
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
